// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: state, grant and latency-counter definitions shared by the memory port arbiter and memory model
package mips_mem_pkg;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch (I) and data (D) stages, D has priority
//   clk/rst        : clock, async active-high reset
//   if_*           : fetch request (req/addr in, rdata/ready out)
//   d_*            : data request (req/we/be/addr/wdata in, rdata/ready out)
//   mem_*          : memory strobe, byte writes, address, write data, read data (MEM_LAT after mem_en)
//   busy           : high whenever an access is in flight (not IDLE)
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, if_ready_q, d_ready_q, busy_q;
  logic [BE_W-1:0]   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, d_rdata_q;
  logic              sample;
  // the memory's read data is valid only in the last WAIT cycle
  assign sample = state_q == WAIT && cnt_q == '0;
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mem_we_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d     = ISSUE;
          gnt_d       = GNT_D;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = d_we ? d_be : '0;
        end else if (if_req) begin
          state_d    = ISSUE;
          gnt_d      = GNT_I;
          mem_addr_d = if_addr;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_INIT;
      end
      WAIT: begin
        cnt_d   = sample ? '0 : cnt_q - 1'b1;
        state_d = sample ? RESP : WAIT;
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_NONE;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= state_d == ISSUE;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= state_d == RESP && gnt_d == GNT_I;
      d_ready_q   <= state_d == RESP && gnt_d == GNT_D;
      busy_q      <= state_d != IDLE;
      if (sample && gnt_q == GNT_I) if_rdata_q <= mem_rdata;
      if (sample && gnt_q == GNT_D) d_rdata_q <= mem_rdata;
    end
  end
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, corner sequences and a randomized transaction-level model check of the arbiter
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic        if_ready, d_ready, mem_en, busy;
  logic [31:0] x1_if_rdata, x1_d_rdata, x1_mem_addr, x1_mem_wdata, x15_if_rdata, x15_d_rdata, x15_mem_addr, x15_mem_wdata;
  logic [3:0]  x1_mem_we, x15_mem_we;
  logic        x1_if_ready, x1_d_ready, x1_mem_en, x1_busy, x15_if_ready, x15_d_ready, x15_mem_en, x15_busy;
  logic [31:0] zero_rdata = '0;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(x1_if_rdata), .if_ready(x1_if_ready),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(x1_d_rdata), .d_ready(x1_d_ready),
    .mem_en(x1_mem_en), .mem_we(x1_mem_we), .mem_addr(x1_mem_addr), .mem_wdata(x1_mem_wdata), .mem_rdata(zero_rdata), .busy(x1_busy));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) u_lat15 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(x15_if_rdata), .if_ready(x15_if_ready),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(x15_d_rdata), .d_ready(x15_d_ready),
    .mem_en(x15_mem_en), .mem_we(x15_mem_we), .mem_addr(x15_mem_addr), .mem_wdata(x15_mem_wdata), .mem_rdata(zero_rdata), .busy(x15_busy));
  // memory model: 2-cycle read pipeline, byte-masked writes, backdoor preload port
  logic [31:0] mem [0:255];
  logic [31:0] rd0, rd1;
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (mem_en) begin
      rd0 <= mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++) if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd1 <= rd0;
  end
  assign mem_rdata = rd1;
  // monitor of the main instance
  int cyc = 0, en_cnt = 0, ir_cnt = 0, dr_cnt = 0, iss_cyc = 0, ir_cyc = 0, dr_cyc = 0;
  logic [31:0] iss_addr, iss_wdata, ir_data, dr_data;
  logic [3:0]  iss_we;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_en) begin
      en_cnt++; iss_cyc = cyc; iss_addr = mem_addr; iss_we = mem_we; iss_wdata = mem_wdata;
    end
    if (if_ready) begin ir_cnt++; ir_cyc = cyc; ir_data = if_rdata; end
    if (d_ready) begin dr_cnt++; dr_cyc = cyc; dr_data = d_rdata; end
  end
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  logic [31:0] ref_mem [0:255];
  task automatic preload(input int idx, input logic [31:0] data);
    bd_we = 1'b1; bd_idx = 8'(idx); bd_data = data; ref_mem[idx] = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask
  task automatic ref_store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
  endtask
  typedef struct {
    bit          is_d;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_we;
  } vec_t;
  task automatic run_vec(input vec_t v, input bit hold_extra);
    int e0, i0, d0, t0;
    bit seen;
    @(negedge clk); #1;
    e0 = en_cnt; i0 = ir_cnt; d0 = dr_cnt; t0 = cyc;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk); #1;
      seen = v.is_d ? dr_cnt != d0 : ir_cnt != i0;
    end
    if (hold_extra) begin @(negedge clk); #1; end
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("ready_seen", 64'(seen), 64'd1);
    chk("issue_cycle", 64'(iss_cyc - t0), 64'd1);
    chk("ready_cycle", 64'((v.is_d ? dr_cyc : ir_cyc) - t0), 64'(2 + LAT));
    chk("mem_en_count", 64'(en_cnt - e0), 64'd1);
    chk("other_ready", 64'(v.is_d ? ir_cnt - i0 : dr_cnt - d0), 64'd0);
    chk("mem_addr", 64'(iss_addr), 64'(v.addr));
    chk("mem_we", 64'(iss_we), 64'(v.exp_we));
    if (v.is_d && v.we) begin
      chk("mem_wdata", 64'(iss_wdata), 64'(v.wdata));
      ref_store(v.addr, v.be, v.wdata);
    end else chk("rdata", 64'(v.is_d ? dr_data : ir_data), 64'(v.exp_rdata));
  endtask
  vec_t tbl [8];
  initial begin
    int t0, e0, i0, en_a, en_b, rd, ri;
    logic [31:0] dv, iv;
    int b2, b1, b15, r2, r1, r15;
    int idle_at, iss_c, rdy_c, c, idx;
    bit s_d, s_we, ion, don, d_known;
    logic [3:0] s_be;
    logic [31:0] s_addr, s_wdata, s_exp, last_if, last_d;
    tbl[0] = '{1'b0, 1'b0, 4'h0, 32'h040, 32'h0, 32'h8C010004, 4'h0};
    tbl[1] = '{1'b1, 1'b1, 4'h3, 32'h100, 32'hDEADBEEF, 32'h0, 4'h3};
    tbl[2] = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 32'h1234BEEF, 4'h0};
    tbl[3] = '{1'b0, 1'b0, 4'h0, 32'h3FC, 32'h0, 32'hCAFEF00D, 4'h0};
    tbl[4] = '{1'b1, 1'b0, 4'hF, 32'h3FC, 32'h99999999, 32'hCAFEF00D, 4'h0};
    tbl[5] = '{1'b1, 1'b1, 4'hC, 32'h3FC, 32'h11223344, 32'h0, 4'hC};
    tbl[6] = '{1'b0, 1'b0, 4'h0, 32'h3FC, 32'h0, 32'h1122F00D, 4'h0};
    tbl[7] = '{1'b1, 1'b1, 4'hF, 32'h040, 32'h00000000, 32'h0, 4'hF};
    #1;
    chk("reset_ctl", 64'({mem_en, mem_we, busy, if_ready, d_ready}), 64'd0);
    chk("reset_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
    chk("reset_rdata", {if_rdata, d_rdata}, 64'd0);
    for (int i = 0; i < 256; i++) preload(i, $urandom);
    preload(16, 32'h8C010004);
    preload(64, 32'h12345678);
    preload(255, 32'hCAFEF00D);
    preload(128, 32'h55AA55AA);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) run_vec(tbl[i], 1'b0);
    // contention: D wins, I follows after RESP/IDLE
    @(negedge clk); #1;
    t0 = cyc; e0 = en_cnt; en_a = -1; en_b = -1; rd = -1; ri = -1; dv = '0; iv = '0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200; if_req = 1'b1; if_addr = 32'h3FC;
    for (int k = 0; k < 40 && ri < 0; k++) begin
      @(negedge clk); #1;
      if (mem_en) begin
        if (en_a < 0) en_a = cyc - t0; else en_b = cyc - t0;
      end
      if (d_ready) begin rd = cyc - t0; dv = d_rdata; d_req = 1'b0; end
      if (if_ready) begin ri = cyc - t0; iv = if_rdata; if_req = 1'b0; end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("cont_mem_en_count", 64'(en_cnt - e0), 64'd2);
    chk("cont_d_issue", 64'(en_a), 64'd1);
    chk("cont_i_issue", 64'(en_b), 64'd6);
    chk("cont_d_ready", 64'(rd), 64'd4);
    chk("cont_i_ready", 64'(ri), 64'd9);
    chk("cont_d_rdata", 64'(dv), 64'(ref_mem[128]));
    chk("cont_i_rdata", 64'(iv), 64'(ref_mem[255]));
    // req held through the ready cycle must not start a second access
    run_vec('{1'b0, 1'b0, 4'h0, 32'h100, 32'h0, ref_mem[64], 4'h0}, 1'b1);
    // reset during the second WAIT cycle
    @(negedge clk); #1;
    t0 = cyc; if_req = 1'b1; if_addr = 32'h3FC;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1; #1;
    chk("midrst_ctl", 64'({mem_en, mem_we, busy, if_ready, d_ready}), 64'd0);
    chk("midrst_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
    chk("midrst_rdata", {if_rdata, d_rdata}, 64'd0);
    if_req = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0; i0 = ir_cnt;
    repeat (8) @(negedge clk);
    #1;
    chk("midrst_no_ready", 64'(ir_cnt - i0), 64'd0);
    run_vec('{1'b0, 1'b0, 4'h0, 32'h040, 32'h0, ref_mem[16], 4'h0}, 1'b0);
    // latency extremes: MEM_LAT 1, 2, 15 share the same fetch; req dropped after the fastest ready
    repeat (20) @(negedge clk);
    #1;
    t0 = cyc; if_req = 1'b1; if_addr = 32'h040;
    b2 = 0; b1 = 0; b15 = 0; r2 = -1; r1 = -1; r15 = -1;
    for (int k = 0; k <= 20; k++) begin
      b2 += int'(busy); b1 += int'(x1_busy); b15 += int'(x15_busy);
      if (if_ready && r2 < 0) r2 = k;
      if (x1_if_ready && r1 < 0) r1 = k;
      if (x15_if_ready && r15 < 0) r15 = k;
      if (r1 >= 0) if_req = 1'b0;
      @(negedge clk); #1;
    end
    chk("lat2_ready", 64'(r2), 64'd4);
    chk("lat1_ready", 64'(r1), 64'd3);
    chk("lat15_ready", 64'(r15), 64'd17);
    chk("lat2_busy", 64'(b2), 64'd4);
    chk("lat1_busy", 64'(b1), 64'd3);
    chk("lat15_busy", 64'(b15), 64'd17);
    // randomized traffic against a transaction-level model
    last_if = ref_mem[16]; last_d = '0; d_known = 1'b1;
    ion = 1'b0; don = 1'b0; s_d = 1'b0; s_we = 1'b0; s_be = '0; s_addr = '0; s_wdata = '0; s_exp = '0;
    @(negedge clk); #1;
    idle_at = cyc; iss_c = -10; rdy_c = -10;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk); #1;
      c = cyc;
      chk("rnd_ctl", 64'({mem_en, busy, if_ready, d_ready}),
          64'({c == iss_c, c >= iss_c && c <= rdy_c, c == rdy_c && !s_d, c == rdy_c && s_d}));
      if (c == iss_c) begin
        chk("rnd_mem_addr", 64'(mem_addr), 64'(s_addr));
        chk("rnd_mem_we", 64'(mem_we), 64'(s_we ? s_be : 4'h0));
        if (s_we) chk("rnd_mem_wdata", 64'(mem_wdata), 64'(s_wdata));
      end
      if (c == rdy_c) begin
        if (!s_d) last_if = s_exp;
        else if (!s_we) begin last_d = s_exp; d_known = 1'b1; end
        else d_known = 1'b0;
      end
      chk("rnd_if_rdata", 64'(if_rdata), 64'(last_if));
      if (d_known) chk("rnd_d_rdata", 64'(d_rdata), 64'(last_d));
      if (if_ready) ion = 1'b0;
      if (d_ready) don = 1'b0;
      if (c >= iss_c && c < rdy_c) begin
        if (s_d) begin d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom); end
        else if_addr = $urandom;
      end
      if (!ion && $urandom_range(2) == 0) begin ion = 1'b1; if_addr = {22'd0, 8'($urandom), 2'b00}; end
      if (!don && $urandom_range(3) == 0) begin
        don = 1'b1; d_we = 1'($urandom); d_be = 4'($urandom); d_addr = {22'd0, 8'($urandom), 2'b00}; d_wdata = $urandom;
      end
      if_req = ion; d_req = don;
      if (c >= idle_at && (d_req || if_req)) begin
        s_d = d_req; s_we = d_req && d_we; s_be = d_be; s_wdata = d_wdata;
        s_addr = d_req ? d_addr : if_addr;
        iss_c = c + 1; rdy_c = c + 2 + LAT; idle_at = c + 3 + LAT;
        idx = int'(s_addr[9:2]);
        s_exp = ref_mem[idx];
        if (s_we) ref_store(s_addr, s_be, s_wdata);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (LAT + 6) @(negedge clk);
    #1;
    chk("final_idle", 64'(busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single synchronous unified memory port of the MIPS core between the instruction-fetch stage (I) and the data-memory stage (D).
- Accepts one request at a time and sequences it through a fixed-latency memory.
- Returns read data plus a one-cycle ready pulse to the granted requester.
- Sits inside Top, between the IF/MEM pipeline stages and the memory model; stage stall logic derives from req && !ready.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
MEM_LAT, 2, cycles from mem_en-high cycle to mem_rdata valid; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid while if_ready
if_ready  out  1  one-cycle completion pulse to fetch
d_req  in  1  data request, held until d_ready
d_we  in  1  1 = store, 0 = load
d_be  in  DATA_W/8  byte enables for store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid while d_ready
d_ready  out  1  one-cycle completion pulse to data stage
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  DATA_W/8  byte write enables (0 for reads)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate) sets all of the following to 0: mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_ready, d_ready, busy. State goes to IDLE, latency counter to 0, grant to NONE.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: at the clock edge, if d_req is high, grant D (data has fixed priority; it is the older instruction). Else if if_req is high, grant I. Else stay in IDLE.
  - On a grant, capture the granted request's address/we/be/wdata into internal registers and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_addr and mem_wdata come from the captured registers.
  - mem_we = captured be if a D store, else 0. Fetches never write.
  - Load counter with MEM_LAT-1. Next state is WAIT.
- WAIT (exactly MEM_LAT cycles):
  - mem_en=0; mem_we forced to 0.
  - Counter decrements each cycle. In the cycle where the counter is 0, mem_rdata is valid; sample it into the granted side's rdata register and go to RESP.
- RESP (exactly 1 cycle):
  - Granted side's ready=1 and its rdata is valid; the other side stays 0.
  - Next state is IDLE, grant returns to NONE.
  - RESP exists so a req still high during the ready cycle is not re-sampled as a new access.
- Timing: request sampled in IDLE at cycle t gives ISSUE at t+1 and ready at t+2+MEM_LAT. Back-to-back access period is MEM_LAT+3 cycles.
- Stores also complete with a ready pulse at the same timing. For stores, d_rdata holds the mem_rdata sampled in WAIT (don't-care to the requester).
- rdata registers hold their value until the next completion on the same side.
- Simultaneous if_req and d_req in IDLE: D wins. I is served on the next IDLE sample if if_req is still held. No starvation guard is needed: D requests are separated by pipeline progress, which requires fetch.
- req dropped mid-access (protocol violation): the access still completes and ready still pulses. A new request is not accepted until IDLE.
- Request signal changes after capture are ignored.
- Reset mid-access: FSM aborts to IDLE and no ready is issued. A store whose ISSUE cycle already occurred is not undone.

Decomposition:
- Shared package mips_mem_pkg:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
  - grant encoding (GNT_NONE, GNT_I, GNT_D)
  - MEM_LAT_MAX=15 and counter width 4
- The memory model uses the same package.
- No sub-module required. The 4-bit latency down-counter stays inline.

Test Plan (MEM_LAT=2):
1. Fetch read: if_req=1, if_addr=0x00000040 sampled in IDLE at cycle 0, mem model returns 0x8C010004 → mem_en=1/mem_addr=0x40/mem_we=0 in cycle 1; if_ready=1, if_rdata=0x8C010004 in cycle 4 only; d_ready stays 0.
2. Store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEADBEEF → cycle 1 mem_we=4'b0011, mem_wdata=0xDEADBEEF; d_ready=1 in cycle 4. Memory word 0x100 low half becomes 0xBEEF.
3. Contention: if_req and d_req (load from 0x200) both high at cycle 0 → D issued in cycle 1 and d_ready in cycle 4. I issued in cycle 6 and if_ready in cycle 9. Exactly one mem_en per access.
4. Held req across RESP: keep if_req high through its ready cycle, then drop it → only one mem_en pulse.
5. Reset mid-op: assert rst during WAIT cycle 2 → all outputs 0 immediately, no ready pulse; after release, a new fetch completes with normal 4-cycle latency.
6. MEM_LAT=1 and MEM_LAT=15 rebuild: ready occurs exactly MEM_LAT+2 cycles after the request is sampled; busy is high for MEM_LAT+2 cycles.
